// File: rtl/rf_access_arbiter.sv
// Two-requester arbiter for the register file write port and read port 1.
// Core has priority; a saturating starve counter lets debug win one tie.
module rf_access_arbiter #(
   parameter int DATA_W       = 8,
   parameter int ADDR_W       = 3,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              core_req_valid,
   input  logic              core_req_write,
   input  logic [ADDR_W-1:0] core_req_addr,
   input  logic [DATA_W-1:0] core_req_wdata,
   output logic              core_req_ready,
   output logic              core_rsp_valid,
   output logic [DATA_W-1:0] core_rsp_rdata,
   input  logic              dbg_req_valid,
   input  logic              dbg_req_write,
   input  logic [ADDR_W-1:0] dbg_req_addr,
   input  logic [DATA_W-1:0] dbg_req_wdata,
   output logic              dbg_req_ready,
   output logic              dbg_rsp_valid,
   output logic [DATA_W-1:0] dbg_rsp_rdata,
   output logic              rf_reg_write,
   output logic [ADDR_W-1:0] rf_write_addr,
   output logic [DATA_W-1:0] rf_write_data,
   output logic [ADDR_W-1:0] rf_read_addr1,
   input  logic [DATA_W-1:0] rf_read_data1,
   output logic              dbg_starved
);

   localparam int STAGES = 1;
   localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   typedef struct packed {
      logic              src;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   logic [CNT_W-1:0] starve_cnt;
   logic             starved;
   logic             dbg_win;
   logic [STAGES:0]  vld_pipe;
   req_t             acc;
   logic             ex_src;
   logic             ex_wr;

   assign starved     = (starve_cnt == LIMIT);
   assign dbg_starved = starved;

   // Debug takes the port when alone, or on a tie once it has starved.
   assign dbg_win        = dbg_req_valid & (~core_req_valid | starved);
   assign core_req_ready = rst_n & core_req_valid & ~dbg_win;
   assign dbg_req_ready  = rst_n & dbg_win;
   assign vld_pipe[0]    = core_req_ready | dbg_req_ready;

   always_comb begin
      acc = '{src: 1'b0, wr: core_req_write, addr: core_req_addr, wdata: core_req_wdata};
      if (dbg_win)
         acc = '{src: 1'b1, wr: dbg_req_write, addr: dbg_req_addr, wdata: dbg_req_wdata};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (dbg_req_valid & ~dbg_req_ready) begin
         if (!starved) starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
         starve_cnt <= '0;
      end
   end

   // Execute stage: rf ports are driven straight from flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe[STAGES:1] <= '0;
         ex_src             <= 1'b0;
         ex_wr              <= 1'b0;
         rf_reg_write       <= 1'b0;
         rf_write_addr      <= '0;
         rf_write_data      <= '0;
         rf_read_addr1      <= '0;
      end else begin
         vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
         rf_reg_write       <= vld_pipe[0] & acc.wr;
         if (vld_pipe[0]) begin
            ex_src <= acc.src;
            ex_wr  <= acc.wr;
         end
         if (vld_pipe[0] & acc.wr) begin
            rf_write_addr <= acc.addr;
            rf_write_data <= acc.wdata;
         end
         if (vld_pipe[0] & ~acc.wr)
            rf_read_addr1 <= acc.addr;
      end
   end

   // Response stage: rdata holds after the pulse; write acks return zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_rsp_valid <= 1'b0;
         dbg_rsp_valid  <= 1'b0;
         core_rsp_rdata <= '0;
         dbg_rsp_rdata  <= '0;
      end else begin
         core_rsp_valid <= vld_pipe[STAGES] & ~ex_src;
         dbg_rsp_valid  <= vld_pipe[STAGES] & ex_src;
         if (vld_pipe[STAGES] & ~ex_src)
            core_rsp_rdata <= ex_wr ? '0 : rf_read_data1;
         if (vld_pipe[STAGES] & ex_src)
            dbg_rsp_rdata <= ex_wr ? '0 : rf_read_data1;
      end
   end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Bench for rf_access_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level model of grants, latency and memory.
module tb_rf_access_arbiter;
   localparam int DW  = 8;
   localparam int AW  = 3;
   localparam int LIM = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          core_req_valid = 1'b0, core_req_write = 1'b0;
   logic [AW-1:0] core_req_addr = '0;
   logic [DW-1:0] core_req_wdata = '0;
   logic          core_req_ready, core_rsp_valid;
   logic [DW-1:0] core_rsp_rdata;
   logic          dbg_req_valid = 1'b0, dbg_req_write = 1'b0;
   logic [AW-1:0] dbg_req_addr = '0;
   logic [DW-1:0] dbg_req_wdata = '0;
   logic          dbg_req_ready, dbg_rsp_valid;
   logic [DW-1:0] dbg_rsp_rdata;
   logic          rf_reg_write;
   logic [AW-1:0] rf_write_addr, rf_read_addr1;
   logic [DW-1:0] rf_write_data, rf_read_data1;
   logic          dbg_starved;

   rf_access_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst_n(rst_n),
      .core_req_valid(core_req_valid), .core_req_write(core_req_write),
      .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
      .core_req_ready(core_req_ready), .core_rsp_valid(core_rsp_valid),
      .core_rsp_rdata(core_rsp_rdata),
      .dbg_req_valid(dbg_req_valid), .dbg_req_write(dbg_req_write),
      .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
      .dbg_req_ready(dbg_req_ready), .dbg_rsp_valid(dbg_rsp_valid),
      .dbg_rsp_rdata(dbg_rsp_rdata),
      .rf_reg_write(rf_reg_write), .rf_write_addr(rf_write_addr),
      .rf_write_data(rf_write_data), .rf_read_addr1(rf_read_addr1),
      .rf_read_data1(rf_read_data1), .dbg_starved(dbg_starved)
   );

   always #5 clk = ~clk;

   // Register file environment
   logic [DW-1:0] rf_mem [8];
   always @(posedge clk) if (rf_reg_write) rf_mem[rf_write_addr] <= rf_write_data;
   assign rf_read_data1 = rf_mem[rf_read_addr1];

   // Reference model: accepted ops with their accept cycle
   typedef struct {
      int            cyc;
      bit            src;
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [DW-1:0] rdata;
   } op_t;

   op_t           q[$];
   int            cyc = 0;
   int            lost = 0;
   logic [AW-1:0] m_raddr = '0;
   logic [DW-1:0] m_rd [2];
   logic [DW-1:0] m_mem [8];
   int            n_cmp = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit cv, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input bit dv, input bit dw, input logic [AW-1:0] da, input logic [DW-1:0] dd);
      bit  st, e_cr, e_dr, r_has, x_has;
      op_t r, o;
      @(negedge clk);
      core_req_valid = cv; core_req_write = cw; core_req_addr = ca; core_req_wdata = cd;
      dbg_req_valid  = dv; dbg_req_write  = dw; dbg_req_addr  = da; dbg_req_wdata  = dd;
      #1;
      st   = (lost == LIM);
      e_dr = dv && (!cv || st);
      e_cr = cv && !e_dr;
      chk("core_ready", 32'(core_req_ready), 32'(e_cr));
      chk("dbg_ready", 32'(dbg_req_ready), 32'(e_dr));
      chk("dbg_starved", 32'(dbg_starved), 32'(st));
      // op accepted two cycles ago responds now; its write is already committed
      r_has = 0;
      if (q.size() > 0 && q[0].cyc == cyc - 2) begin
         r = q.pop_front();
         r_has = 1;
         if (r.wr) m_mem[r.addr] = r.data;
         m_rd[r.src] = r.wr ? 8'h00 : r.rdata;
      end
      chk("core_rsp_valid", 32'(core_rsp_valid), 32'(r_has && !r.src));
      chk("dbg_rsp_valid", 32'(dbg_rsp_valid), 32'(r_has && r.src));
      chk("core_rsp_rdata", 32'(core_rsp_rdata), 32'(m_rd[0]));
      chk("dbg_rsp_rdata", 32'(dbg_rsp_rdata), 32'(m_rd[1]));
      // op accepted last cycle is on the rf ports now
      x_has = (q.size() > 0 && q[0].cyc == cyc - 1);
      if (x_has) begin
         o = q[0];
         chk("rf_reg_write", 32'(rf_reg_write), 32'(o.wr));
         if (o.wr) begin
            chk("rf_write_addr", 32'(rf_write_addr), 32'(o.addr));
            chk("rf_write_data", 32'(rf_write_data), 32'(o.data));
         end else begin
            m_raddr = o.addr;
            q[0].rdata = m_mem[o.addr];
         end
      end else begin
         chk("rf_reg_write_idle", 32'(rf_reg_write), 32'd0);
      end
      if (!(x_has && o.wr)) chk("rf_read_addr1", 32'(rf_read_addr1), 32'(m_raddr));
      if (e_cr || e_dr)
         q.push_back('{cyc: cyc, src: e_dr, wr: (e_dr ? dw : cw), addr: (e_dr ? da : ca),
                       data: (e_dr ? dd : cd), rdata: 8'h00});
      lost = (dv && !e_dr) ? ((lost < LIM) ? lost + 1 : LIM) : 0;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_core_ready", 32'(core_req_ready), 32'd0);
      chk("rst_dbg_ready", 32'(dbg_req_ready), 32'd0);
      chk("rst_rf_reg_write", 32'(rf_reg_write), 32'd0);
      chk("rst_rf_write_addr", 32'(rf_write_addr), 32'd0);
      chk("rst_rf_write_data", 32'(rf_write_data), 32'd0);
      chk("rst_rf_read_addr1", 32'(rf_read_addr1), 32'd0);
      chk("rst_core_rsp", 32'({core_rsp_valid, core_rsp_rdata}), 32'd0);
      chk("rst_dbg_rsp", 32'({dbg_rsp_valid, dbg_rsp_rdata}), 32'd0);
      chk("rst_dbg_starved", 32'(dbg_starved), 32'd0);
      q.delete();
      lost = 0; m_raddr = '0; m_rd[0] = '0; m_rd[1] = '0;
      repeat (2) @(negedge clk);
      core_req_valid = 1'b1; dbg_req_valid = 1'b1;
      #1;
      chk("rst_hold_core_ready", 32'(core_req_ready), 32'd0);
      chk("rst_hold_dbg_ready", 32'(dbg_req_ready), 32'd0);
      core_req_valid = 1'b0; dbg_req_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [DW-1:0] pre [8];
      m_rd[0] = '0; m_rd[1] = '0;
      core_req_valid = 1'b1; dbg_req_valid = 1'b1;
      #2;
      do_reset();

      // Preload every register through the arbiter
      for (int i = 0; i < 8; i++) pre[i] = DW'($urandom);
      pre[7] = 8'h3C; pre[5] = 8'h77;
      for (int i = 0; i < 8; i++) step(1, 1, AW'(i), pre[i], 0, 0, 0, 0);
      idle(2);

      // Write then read-after-write on R3
      step(1, 1, 3'd3, 8'hA5, 0, 0, 0, 0);
      step(1, 0, 3'd3, 8'h00, 0, 0, 0, 0);
      idle(2);
      chk("raw_r3_rdata", 32'(core_rsp_rdata), 32'h0000_00A5);

      // Continuous contention: 4:1 core/debug pattern
      for (int i = 0; i < 15; i++)
         step(1, 0, AW'($urandom), 8'h00, 1, 0, AW'($urandom), 8'h00);
      idle(3);

      // Debug-only read of R7
      step(0, 0, 0, 0, 1, 0, 3'd7, 8'h00);
      idle(2);
      chk("dbg_r7_rdata", 32'(dbg_rsp_rdata), 32'h0000_003C);

      // Alternating back-to-back writes, then read both back
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) step(1, 1, 3'd0, 8'h11, 0, 0, 0, 0);
         else            step(0, 0, 0, 0, 1, 1, 3'd1, 8'h22);
      end
      step(1, 0, 3'd0, 8'h00, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 3'd1, 8'h00);
      idle(2);
      chk("alt_r0", 32'(core_rsp_rdata), 32'h0000_0011);
      chk("alt_r1", 32'(dbg_rsp_rdata), 32'h0000_0022);

      // Reset while a write to R5 sits in execute
      step(1, 1, 3'd5, 8'hEE, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      do_reset();
      idle(3);
      step(0, 0, 0, 0, 1, 0, 3'd5, 8'h00);
      idle(2);
      chk("r5_after_reset", 32'(dbg_rsp_rdata), 32'h0000_0077);

      // Random traffic
      for (int i = 0; i < 400; i++)
         step(($urandom_range(3) != 0), 1'($urandom), AW'($urandom), DW'($urandom),
              1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
      idle(3);

      for (int i = 0; i < 8; i++) chk("rf_mem_final", 32'(rf_mem[i]), 32'(m_mem[i]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
